// File: rtl/abridor_de_porta.sv
// Automatic door-opener controller: synchronizes the c/h/p switches and drives
// a registered door-open command F with a post-release hold timer.
module abridor_de_porta #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic c,
    input  logic h,
    input  logic p,
    output logic F
);

    typedef enum logic [1:0] {
        ST_CLOSED = 2'd0,
        ST_OPEN   = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    // Entering HOLD already consumes one of the hold cycles, hence the -1.
    localparam logic [7:0] HOLD_LOAD = (HOLD_CYCLES == 0) ? 8'd0 : 8'(HOLD_CYCLES - 1);
    localparam bit         HOLD_EN   = (HOLD_CYCLES != 0);

    logic [SYNC_STAGES-1:0] c_sync_q;
    logic [SYNC_STAGES-1:0] h_sync_q;
    logic [SYNC_STAGES-1:0] p_sync_q;
    logic                   c_s;
    logic                   h_s;
    logic                   p_s;
    logic                   open_req;

    state_e                 state_q;
    state_e                 state_d;
    logic [7:0]             cnt_q;
    logic [7:0]             cnt_d;
    logic                   f_q;
    logic                   f_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_sync_q <= '0;
            h_sync_q <= '0;
            p_sync_q <= '0;
        end else begin
            c_sync_q <= {c_sync_q[SYNC_STAGES-2:0], c};
            h_sync_q <= {h_sync_q[SYNC_STAGES-2:0], h};
            p_sync_q <= {p_sync_q[SYNC_STAGES-2:0], p};
        end
    end

    assign c_s      = c_sync_q[SYNC_STAGES-1];
    assign h_s      = h_sync_q[SYNC_STAGES-1];
    assign p_s      = p_sync_q[SYNC_STAGES-1];
    assign open_req = ~c_s & (h_s | p_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLOSED;
            cnt_q   <= 8'd0;
            f_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f_q     <= f_d;
        end
    end

    // Priority: close override, then open request, then hold expiry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLOSED: begin
                if (open_req) begin
                    state_d = ST_OPEN;
                end
            end
            ST_OPEN: begin
                if (c_s) begin
                    state_d = ST_CLOSED;
                end else if (!open_req) begin
                    if (HOLD_EN) begin
                        state_d = ST_HOLD;
                        cnt_d   = HOLD_LOAD;
                    end else begin
                        state_d = ST_CLOSED;
                    end
                end
            end
            ST_HOLD: begin
                if (c_s) begin
                    state_d = ST_CLOSED;
                end else if (open_req) begin
                    state_d = ST_OPEN;
                end else if (cnt_q == 8'd0) begin
                    state_d = ST_CLOSED;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_CLOSED;
            end
        endcase
    end

    always_comb begin
        f_d = (state_d != ST_CLOSED);
    end

    assign F = f_q;

endmodule

// File: tb/tb_abridor_de_porta.sv
// Bench for abridor_de_porta: one instance with default hold, one with no hold,
// checked against a door model every cycle plus directed literal expectations.
module tb_abridor_de_porta;

  localparam int SYNC = 2;
  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic c = 1'b0;
  logic h = 1'b0;
  logic p = 1'b0;
  logic f4;
  logic f0;

  int checks = 0;
  int errors = 0;

  abridor_de_porta #(.SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD)) dut_h4 (
    .clk(clk), .rst_n(rst_n), .c(c), .h(h), .p(p), .F(f4)
  );

  abridor_de_porta #(.SYNC_STAGES(SYNC), .HOLD_CYCLES(0)) dut_h0 (
    .clk(clk), .rst_n(rst_n), .c(c), .h(h), .p(p), .F(f0)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Inputs sampled at each edge since reset; the controller sees a sample SYNC
  // edges later. The door is open while requested, and for HOLD more edges
  // after the request goes away, unless close is seen.
  logic [2:0] in_log[$];
  logic       exp4 = 1'b0;
  logic [7:0] left4 = 8'd0;
  logic       exp0 = 1'b0;
  logic [7:0] left0 = 8'd0;

  function automatic logic [2:0] seen_inputs();
    if (in_log.size() >= SYNC) return in_log[in_log.size() - SYNC];
    return 3'b000;
  endfunction

  function automatic logic [8:0] door_next(input logic [2:0] chp, input logic [7:0] left,
                                           input int hold);
    logic close_s;
    logic want;
    close_s = chp[2];
    want = ~chp[2] & (chp[1] | chp[0]);
    if (close_s) return 9'd0;
    if (want) return {1'b1, 8'(hold)};
    if (left != 8'd0) return {1'b1, left - 8'd1};
    return 9'd0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_log.delete();
      exp4 <= 1'b0;
      left4 <= 8'd0;
      exp0 <= 1'b0;
      left0 <= 8'd0;
    end else begin
      {exp4, left4} <= door_next(seen_inputs(), left4, HOLD);
      {exp0, left0} <= door_next(seen_inputs(), left0, 0);
      in_log.push_back({c, h, p});
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    checks++;
    if (f4 !== exp4) begin
      errors++;
      $display("FAIL model_h4 t=%0t F=%0b expected %0b", $time, f4, exp4);
    end
    checks++;
    if (f0 !== exp0) begin
      errors++;
      $display("FAIL model_h0 t=%0t F=%0b expected %0b", $time, f0, exp0);
    end
  end

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0b expected %0b", name, $time, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [7:0] tt;
    int k4;
    int k0;
    tt = 8'b0000_1110;

    // Reset held with a person present: door stays shut.
    p = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_hold_h4", f4, 1'b0);
      check("rst_hold_h0", f0, 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_edge1", f4, 1'b0);
    @(negedge clk);
    check("rel_edge2", f4, 1'b0);
    @(negedge clk);
    check("rel_edge3", f4, 1'b1);
    check("rel_edge3_h0", f0, 1'b1);

    // Reset asserted mid-cycle while open.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_h4", f4, 1'b0);
    check("async_rst_h0", f0, 1'b0);
    @(negedge clk);
    p = 1'b0;
    rst_n = 1'b1;
    wait_cycles(5);

    // Truth-table sweep on the no-hold instance.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      logic prev_f;
      logic new_f;
      v = 3'(i);
      prev_f = (i == 0) ? 1'b0 : tt[i-1];
      new_f = tt[i];
      {c, h, p} = v;
      @(negedge clk);
      @(negedge clk);
      check("tt_edge2", f0, prev_f);
      @(negedge clk);
      check("tt_edge3", f0, new_f);
      wait_cycles(7);
      check("tt_settled", f0, new_f);
    end
    {c, h, p} = 3'b000;
    wait_cycles(6);

    // Hold timer: drop point with and without hold differs by HOLD cycles.
    p = 1'b1;
    wait_cycles(5);
    check("hold_open_h4", f4, 1'b1);
    p = 1'b0;
    k4 = 0;
    k0 = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (!f4 && k4 == 0) k4 = k;
      if (!f0 && k0 == 0) k0 = k;
    end
    check("hold_drop_h0_at3", (k0 == 3), 1'b1);
    check("hold_drop_h4_at7", (k4 == 7), 1'b1);
    if (k4 != 7 || k0 != 3) $display("  drop edges: h4=%0d h0=%0d", k4, k0);

    // Close override during HOLD.
    p = 1'b1;
    wait_cycles(5);
    p = 1'b0;
    @(negedge clk);
    c = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("close_in_hold", f4, 1'b1);
    @(negedge clk);
    check("close_after3", f4, 1'b0);
    h = 1'b1;
    p = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("close_overrides_h4", f4, 1'b0);
      check("close_overrides_h0", f0, 1'b0);
    end
    {c, h, p} = 3'b000;
    wait_cycles(5);

    // Retrigger while hold counter is at 2.
    p = 1'b1;
    wait_cycles(5);
    p = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      check("retrigger", f4, (k <= 10));
      if (k == 2) p = 1'b1;
      if (k == 4) p = 1'b0;
    end
    wait_cycles(3);

    // Glitch shorter than half a period between edges.
    @(posedge clk);
    #2 p = 1'b1;
    #2 p = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("glitch_h4", f4, 1'b0);
      check("glitch_h0", f0, 1'b0);
    end

    wait_cycles(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
